// File: rtl/bgpu_pkg.sv
// Shared bgpu definitions used by the thread-group launcher.
// The launch-entry layout {pc, dp_addr, num_tblocks, tgroup_id} depends on
// per-instance widths. Packages cannot take parameters, so this package
// provides the entry-width helper. Each instance declares its own packed
// struct with the same field order.
package bgpu_pkg;

    // Width of one packed launch entry {pc, dp_addr, num_tblocks, tgroup_id}.
    function automatic int unsigned launch_entry_bits(
        input int unsigned pc_width,
        input int unsigned address_width,
        input int unsigned tblock_idx_bits,
        input int unsigned tgroup_id_bits
    );
        return pc_width + address_width + tblock_idx_bits + tgroup_id_bits;
    endfunction

endpackage

// File: rtl/tgroup_launch_fifo.sv
// Synchronous-reset launch FIFO without fall-through.
// A word pushed in cycle N appears on data_o from cycle N+1.
// data_o reads as zero while the FIFO is empty.
// Ports:
//   clk_i, rst_ni      clock, synchronous active-low reset
//   push_i, data_i     write request and write data
//   pop_i              remove the head word (ignored when empty)
//   data_o             head word
//   full_o, empty_o    occupancy flags
module tgroup_launch_fifo
    import bgpu_pkg::*;
#(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic [Width-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PtrBits = $clog2(Depth);

    logic [Width-1:0] mem [Depth];
    logic [PtrBits:0] wr_ptr;
    logic [PtrBits:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // The pointers carry one extra wrap bit, so full and empty are distinct.
    assign empty_o = (wr_ptr == rd_ptr);
    assign full_o  = (wr_ptr[PtrBits] != rd_ptr[PtrBits]) &&
                     (wr_ptr[PtrBits-1:0] == rd_ptr[PtrBits-1:0]);

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign data_o  = empty_o ? '0 : mem[rd_ptr[PtrBits-1:0]];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr[PtrBits-1:0]] <= data_i;
    end

endmodule

// File: rtl/tgroup_launcher.sv
// Thread-group launcher.
// Accepts kernel launch requests from the host and assigns each one a
// thread-group ID in round-robin order. Accepted requests are queued for
// the dispatcher. For every in-flight group the launcher counts outstanding
// thread blocks, and it pulses tgroup_done_o when the last block finishes.
// Ports:
//   clk_i, rst_ni                      clock, synchronous active-low reset
//   req_*                              host launch handshake; req_tgroup_id_o = next ID
//   disp_*                             head of the launch queue toward the dispatcher
//   tblock_done_i/_tgroup_id_i         per-block completion reports
//   tgroup_done_o/_id_o                one-cycle group-complete pulse
//   idle_o                             nothing queued, nothing in flight
//   error_o                            sticky: completion reported for a group not in flight
module tgroup_launcher
    import bgpu_pkg::*;
#(
    parameter int unsigned PcWidth       = 16,
    parameter int unsigned AddressWidth  = 32,
    parameter int unsigned TblockIdxBits = 8,
    parameter int unsigned TgroupIdBits  = 3,
    parameter int unsigned QueueDepth    = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic [PcWidth-1:0]       req_pc_i,
    input  logic [AddressWidth-1:0]  req_dp_addr_i,
    input  logic [TblockIdxBits-1:0] req_num_tblocks_i,
    output logic [TgroupIdBits-1:0]  req_tgroup_id_o,
    input  logic                     disp_ready_i,
    output logic                     disp_start_o,
    output logic [PcWidth-1:0]       disp_pc_o,
    output logic [AddressWidth-1:0]  disp_dp_addr_o,
    output logic [TblockIdxBits-1:0] disp_num_tblocks_o,
    output logic [TgroupIdBits-1:0]  disp_tgroup_id_o,
    input  logic                     tblock_done_i,
    input  logic [TgroupIdBits-1:0]  tblock_done_tgroup_id_i,
    output logic                     tgroup_done_o,
    output logic [TgroupIdBits-1:0]  tgroup_done_id_o,
    output logic                     idle_o,
    output logic                     error_o
);

    localparam int unsigned NumIds     = 2 ** TgroupIdBits;
    localparam int unsigned EntryWidth =
        launch_entry_bits(PcWidth, AddressWidth, TblockIdxBits, TgroupIdBits);

    typedef struct packed {
        logic [PcWidth-1:0]       pc;
        logic [AddressWidth-1:0]  dp_addr;
        logic [TblockIdxBits-1:0] num_tblocks;
        logic [TgroupIdBits-1:0]  tgroup_id;
    } launch_entry_t;

    logic [TgroupIdBits-1:0]  next_id;
    logic [NumIds-1:0]        in_flight;
    logic [TblockIdxBits-1:0] outstanding [NumIds];
    logic                     done_q;
    logic [TgroupIdBits-1:0]  done_id_q;
    logic                     error_q;

    logic                     fifo_full;
    logic                     fifo_empty;
    logic                     accept;
    logic                     push;
    logic                     pop;
    logic                     done_valid;
    launch_entry_t            push_entry;
    launch_entry_t            head_entry;

    assign req_ready_o     = !fifo_full && !in_flight[next_id];
    assign req_tgroup_id_o = next_id;
    assign accept          = req_valid_i && req_ready_o;
    // Zero-block requests complete the handshake but leave no trace.
    assign push            = accept && (req_num_tblocks_i != '0);
    assign pop             = disp_start_o && disp_ready_i;
    assign done_valid      = tblock_done_i && in_flight[tblock_done_tgroup_id_i];

    always_comb begin
        push_entry             = '0;
        push_entry.pc          = req_pc_i;
        push_entry.dp_addr     = req_dp_addr_i;
        push_entry.num_tblocks = req_num_tblocks_i;
        push_entry.tgroup_id   = next_id;
    end

    tgroup_launch_fifo #(
        .Width (EntryWidth),
        .Depth (QueueDepth)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .data_i  (push_entry),
        .pop_i   (pop),
        .data_o  (head_entry),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign disp_start_o       = !fifo_empty;
    assign disp_pc_o          = head_entry.pc;
    assign disp_dp_addr_o     = head_entry.dp_addr;
    assign disp_num_tblocks_o = head_entry.num_tblocks;
    assign disp_tgroup_id_o   = head_entry.tgroup_id;

    assign tgroup_done_o    = done_q;
    assign tgroup_done_id_o = done_id_q;
    assign error_o          = error_q;
    assign idle_o           = fifo_empty && (in_flight == '0);

    // An accept always targets a group that is not in flight. A completion
    // always targets a group that is in flight. So both can update the
    // table in the same cycle without touching the same entry.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            next_id   <= '0;
            in_flight <= '0;
            done_q    <= 1'b0;
            done_id_q <= '0;
            error_q   <= 1'b0;
            for (int unsigned i = 0; i < NumIds; i++) begin
                outstanding[i] <= '0;
            end
        end else begin
            done_q    <= 1'b0;
            done_id_q <= '0;

            if (push) begin
                in_flight[next_id]   <= 1'b1;
                outstanding[next_id] <= req_num_tblocks_i;
                next_id              <= next_id + 1'b1;
            end

            if (done_valid) begin
                outstanding[tblock_done_tgroup_id_i] <=
                    outstanding[tblock_done_tgroup_id_i] - 1'b1;
                if (outstanding[tblock_done_tgroup_id_i] == TblockIdxBits'(1)) begin
                    in_flight[tblock_done_tgroup_id_i] <= 1'b0;
                    done_q    <= 1'b1;
                    done_id_q <= tblock_done_tgroup_id_i;
                end
            end else if (tblock_done_i) begin
                error_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_tgroup_launcher.sv
module tb_tgroup_launcher;

    localparam int PW   = 16;
    localparam int AW   = 32;
    localparam int TB   = 8;
    localparam int IB   = 3;
    localparam int QD   = 4;
    localparam int NIDS = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic [PW-1:0] req_pc;
    logic [AW-1:0] req_dp;
    logic [TB-1:0] req_num;
    logic [IB-1:0] req_id;
    logic          disp_ready;
    logic          disp_start;
    logic [PW-1:0] disp_pc;
    logic [AW-1:0] disp_dp;
    logic [TB-1:0] disp_num;
    logic [IB-1:0] disp_id;
    logic          blk_done;
    logic [IB-1:0] blk_done_id;
    logic          grp_done;
    logic [IB-1:0] grp_done_id;
    logic          idle;
    logic          err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    tgroup_launcher #(
        .PcWidth       (PW),
        .AddressWidth  (AW),
        .TblockIdxBits (TB),
        .TgroupIdBits  (IB),
        .QueueDepth    (QD)
    ) dut (
        .clk_i                   (clk),
        .rst_ni                  (rst_n),
        .req_valid_i             (req_valid),
        .req_ready_o             (req_ready),
        .req_pc_i                (req_pc),
        .req_dp_addr_i           (req_dp),
        .req_num_tblocks_i       (req_num),
        .req_tgroup_id_o         (req_id),
        .disp_ready_i            (disp_ready),
        .disp_start_o            (disp_start),
        .disp_pc_o               (disp_pc),
        .disp_dp_addr_o          (disp_dp),
        .disp_num_tblocks_o      (disp_num),
        .disp_tgroup_id_o        (disp_id),
        .tblock_done_i           (blk_done),
        .tblock_done_tgroup_id_i (blk_done_id),
        .tgroup_done_o           (grp_done),
        .tgroup_done_id_o        (grp_done_id),
        .idle_o                  (idle),
        .error_o                 (err)
    );

    // Reference model: a queue of launches waiting for the dispatcher, and
    // the remaining block count per group ID (0 means not in flight).
    typedef struct {
        logic [PW-1:0] pc;
        logic [AW-1:0] dp;
        logic [TB-1:0] num;
        int            id;
    } ent_t;

    ent_t m_q[$];
    int   m_rem[NIDS];
    int   m_next;
    bit   m_err;
    bit   m_done;
    int   m_done_id;

    function automatic bit m_ready();
        return (m_q.size() < QD) && (m_rem[m_next] == 0);
    endfunction

    function automatic bit m_idle();
        bit any = 0;
        for (int i = 0; i < NIDS; i++) if (m_rem[i] != 0) any = 1;
        return (m_q.size() == 0) && !any;
    endfunction

    function automatic logic [69:0] m_expected();
        logic [PW-1:0] pc = '0;
        logic [AW-1:0] dp = '0;
        logic [TB-1:0] num = '0;
        logic [IB-1:0] id = '0;
        if (m_q.size() > 0) begin
            pc  = m_q[0].pc;
            dp  = m_q[0].dp;
            num = m_q[0].num;
            id  = IB'(m_q[0].id);
        end
        return {m_ready(), IB'(m_next), m_q.size() > 0, pc, dp, num, id,
                m_done, IB'(m_done_id), m_idle(), m_err};
    endfunction

    // Apply one clock edge to the model, using the inputs present at that edge.
    task automatic model_step();
        bit rdy;
        bit st;
        bit nd = 0;
        int nid = 0;
        if (!rst_n) begin
            m_q.delete();
            for (int i = 0; i < NIDS; i++) m_rem[i] = 0;
            m_next = 0; m_err = 0; m_done = 0; m_done_id = 0;
            return;
        end
        rdy = m_ready();
        st  = m_q.size() > 0;
        if (blk_done) begin
            if (m_rem[blk_done_id] == 0) m_err = 1;
            else begin
                m_rem[blk_done_id]--;
                if (m_rem[blk_done_id] == 0) begin nd = 1; nid = int'(blk_done_id); end
            end
        end
        if (st && disp_ready) void'(m_q.pop_front());
        if (req_valid && rdy && req_num != 0) begin
            m_q.push_back('{pc: req_pc, dp: req_dp, num: req_num, id: m_next});
            m_rem[m_next] = int'(req_num);
            m_next = (m_next + 1) % NIDS;
        end
        m_done    = nd;
        m_done_id = nd ? nid : 0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle_inputs();
        req_valid = 0; req_pc = '0; req_dp = '0; req_num = '0;
        disp_ready = 0; blk_done = 0; blk_done_id = '0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst_n = 0;
        tick();
        tick();
        rst_n = 1;
    endtask

    task automatic test_reset();
        logic [69:0] exp_v;
        logic [69:0] got;
        apply_reset();
        // ready=1, id=0, start=0, disp_*=0, done=0, done_id=0, idle=1, error=0
        exp_v = {1'b1, 3'd0, 1'b0, 16'h0, 32'h0, 8'h0, 3'd0, 1'b0, 3'd0, 1'b1, 1'b0};
        got = {req_ready, req_id, disp_start, disp_pc, disp_dp, disp_num, disp_id,
               grp_done, grp_done_id, idle, err};
        checks++;
        if (got !== exp_v) begin
            errors++;
            $display("FAIL reset_state: got %h expected %h", got, exp_v);
        end
    endtask

    task automatic test_single_launch();
        apply_reset();
        disp_ready = 1;
        req_valid = 1; req_pc = 16'h0040; req_dp = 32'h1000_0000; req_num = 8'd3;
        tick();
        req_valid = 0;
        checks++;
        if ({disp_start, disp_pc, disp_num, disp_id} !== {1'b1, 16'h0040, 8'd3, 3'd0}) begin
            errors++;
            $display("FAIL single_dispatch: got %h expected %h",
                     {disp_start, disp_pc, disp_num, disp_id}, {1'b1, 16'h0040, 8'd3, 3'd0});
        end
        tick();
        checks++;
        if ({disp_start, idle, req_id} !== {1'b0, 1'b0, 3'd1}) begin
            errors++;
            $display("FAIL single_popped: got start/idle/id %b%b%0d expected 0 0 1",
                     disp_start, idle, req_id);
        end
        blk_done = 1; blk_done_id = 3'd0;
        tick();
        tick();
        checks++;
        if (grp_done !== 1'b0) begin
            errors++;
            $display("FAIL single_early_done: got %b expected 0", grp_done);
        end
        tick();
        blk_done = 0;
        checks++;
        if ({grp_done, grp_done_id} !== {1'b1, 3'd0}) begin
            errors++;
            $display("FAIL single_done_pulse: got %b/%0d expected 1/0", grp_done, grp_done_id);
        end
        tick();
        checks++;
        if ({grp_done, idle, err} !== 3'b010) begin
            errors++;
            $display("FAIL single_after_done: got done/idle/err %b expected 010",
                     {grp_done, idle, err});
        end
    endtask

    task automatic test_fifo_full();
        apply_reset();
        disp_ready = 0;
        for (int i = 0; i < 4; i++) begin
            req_valid = 1; req_pc = PW'(16'h0100 + i); req_num = 8'd2;
            tick();
        end
        req_valid = 0;
        checks++;
        if ({req_ready, disp_start} !== 2'b01) begin
            errors++;
            $display("FAIL fifo_full_ready: got ready/start %b expected 01", {req_ready, disp_start});
        end
        tick();
        checks++;
        if ({disp_pc, disp_id} !== {16'h0100, 3'd0}) begin
            errors++;
            $display("FAIL fifo_hold: got %h expected %h", {disp_pc, disp_id}, {16'h0100, 3'd0});
        end
        disp_ready = 1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({disp_start, disp_pc, disp_id} !== {1'b1, PW'(16'h0100 + i), IB'(i)}) begin
                errors++;
                $display("FAIL fifo_order[%0d]: got %h expected %h", i,
                         {disp_start, disp_pc, disp_id}, {1'b1, PW'(16'h0100 + i), IB'(i)});
            end
            tick();
        end
        checks++;
        if (disp_start !== 1'b0) begin
            errors++;
            $display("FAIL fifo_drained: got %b expected 0", disp_start);
        end
    endtask

    task automatic test_id_wrap();
        apply_reset();
        disp_ready = 1;
        for (int i = 0; i < 8; i++) begin
            req_valid = 1; req_pc = PW'(i); req_num = 8'd1;
            tick();
        end
        req_valid = 0;
        tick();
        checks++;
        if ({req_ready, req_id} !== {1'b0, 3'd0}) begin
            errors++;
            $display("FAIL wrap_blocked: got ready/id %b/%0d expected 0/0", req_ready, req_id);
        end
        blk_done = 1; blk_done_id = 3'd0;
        tick();
        blk_done = 0;
        checks++;
        if ({grp_done, grp_done_id, req_ready} !== {1'b1, 3'd0, 1'b1}) begin
            errors++;
            $display("FAIL wrap_release: got done/id/ready %b/%0d/%b expected 1/0/1",
                     grp_done, grp_done_id, req_ready);
        end
        req_valid = 1; req_pc = 16'hBEEF; req_num = 8'd1;
        tick();
        req_valid = 0;
        checks++;
        if ({disp_start, disp_pc, disp_id, req_id} !== {1'b1, 16'hBEEF, 3'd0, 3'd1}) begin
            errors++;
            $display("FAIL wrap_reuse: got %h expected %h",
                     {disp_start, disp_pc, disp_id, req_id}, {1'b1, 16'hBEEF, 3'd0, 3'd1});
        end
    endtask

    task automatic test_zero_blocks();
        bit pulsed = 0;
        apply_reset();
        disp_ready = 1;
        req_valid = 1; req_pc = 16'h0077; req_num = 8'd0;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL zero_ready: got %b expected 1", req_ready);
        end
        tick();
        req_valid = 0;
        for (int i = 0; i < 3; i++) begin
            if (grp_done !== 1'b0 || disp_start !== 1'b0) pulsed = 1;
            tick();
        end
        checks++;
        if ({pulsed, req_id, idle} !== {1'b0, 3'd0, 1'b1}) begin
            errors++;
            $display("FAIL zero_discard: got pulsed/id/idle %b/%0d/%b expected 0/0/1",
                     pulsed, req_id, idle);
        end
    endtask

    task automatic test_error();
        apply_reset();
        blk_done = 1; blk_done_id = 3'd5;
        tick();
        blk_done = 0;
        checks++;
        if ({err, grp_done} !== 2'b10) begin
            errors++;
            $display("FAIL error_set: got err/done %b expected 10", {err, grp_done});
        end
        tick(); tick();
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL error_sticky: got %b expected 1", err);
        end
        apply_reset();
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL error_cleared: got %b expected 0", err);
        end
    endtask

    task automatic test_reset_mid();
        logic [69:0] exp_v;
        logic [69:0] got;
        apply_reset();
        disp_ready = 1;
        req_valid = 1; req_pc = 16'h0011; req_num = 8'd1;
        tick();
        req_valid = 0;
        tick();
        disp_ready = 0;
        req_valid = 1; req_pc = 16'h0022; req_num = 8'd2;
        tick();
        req_pc = 16'h0033;
        tick();
        req_valid = 0;
        // Completion of the dispatched group lands in the reset cycle.
        blk_done = 1; blk_done_id = 3'd0;
        rst_n = 0;
        tick();
        rst_n = 1;
        blk_done = 0;
        exp_v = {1'b1, 3'd0, 1'b0, 16'h0, 32'h0, 8'h0, 3'd0, 1'b0, 3'd0, 1'b1, 1'b0};
        got = {req_ready, req_id, disp_start, disp_pc, disp_dp, disp_num, disp_id,
               grp_done, grp_done_id, idle, err};
        checks++;
        if (got !== exp_v) begin
            errors++;
            $display("FAIL reset_mid_op: got %h expected %h", got, exp_v);
        end
    endtask

    task automatic test_random();
        logic [69:0] exp_v;
        logic [69:0] got;
        int live[$];
        apply_reset();
        for (int c = 0; c < 1500; c++) begin
            exp_v = m_expected();
            got = {req_ready, req_id, disp_start, disp_pc, disp_dp, disp_num, disp_id,
                   grp_done, grp_done_id, idle, err};
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL random[%0d]: got %h expected %h", c, got, exp_v);
            end
            req_valid  = ($urandom_range(0, 3) != 0);
            req_pc     = PW'($urandom);
            req_dp     = $urandom;
            req_num    = ($urandom_range(0, 7) == 0) ? 8'd0 : TB'($urandom_range(1, 4));
            disp_ready = ($urandom_range(0, 2) != 0);
            live.delete();
            for (int i = 0; i < NIDS; i++) if (m_rem[i] != 0) live.push_back(i);
            blk_done = 0;
            if ($urandom_range(0, 99) < 65 && live.size() > 0) begin
                blk_done = 1;
                blk_done_id = IB'(live[$urandom_range(0, live.size() - 1)]);
            end else if ($urandom_range(0, 299) == 0) begin
                blk_done = 1;
                blk_done_id = IB'($urandom_range(0, NIDS - 1));
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        rst_n = 0;
        idle_inputs();
        m_next = 0; m_err = 0; m_done = 0; m_done_id = 0;
        for (int i = 0; i < NIDS; i++) m_rem[i] = 0;
        test_reset();
        test_single_launch();
        test_fifo_full();
        test_id_wrap();
        test_zero_blocks();
        test_error();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tgroup_launcher.md
TGROUP_LAUNCHER -- requirements
Module: tgroup_launcher

Interface
REQ-001 SHALL have parameter PcWidth, default 16, program counter width in bits.
REQ-002 SHALL have parameter AddressWidth, default 32, memory address width in bits.
REQ-003 SHALL have parameter TblockIdxBits, default 8, width of the thread-block count.
REQ-004 SHALL have parameter TgroupIdBits, default 3, width of the thread-group ID; the table holds 2**TgroupIdBits entries.
REQ-005 SHALL have parameter QueueDepth, default 4, launch FIFO entries; power of two, at least 2.
REQ-006 SHALL use one clock, clk_i, and a synchronous active-low reset, rst_ni.
REQ-007 SHALL have ports:
 clk_i  in  1  clock
 rst_ni  in  1  synchronous active-low reset
 req_valid_i  in  1  host launch request valid
 req_ready_o  out  1  launcher accepts request
 req_pc_i  in  PcWidth  kernel start PC
 req_dp_addr_i  in  AddressWidth  data/parameter address
 req_num_tblocks_i  in  TblockIdxBits  thread blocks in group
 req_tgroup_id_o  out  TgroupIdBits  ID assigned to the request in the accepting cycle
 disp_ready_i  in  1  dispatcher ready for a new group
 disp_start_o  out  1  group available to dispatcher
 disp_pc_o  out  PcWidth  group PC
 disp_dp_addr_o  out  AddressWidth  group data/parameter address
 disp_num_tblocks_o  out  TblockIdxBits  group block count
 disp_tgroup_id_o  out  TgroupIdBits  group ID
 tblock_done_i  in  1  a thread block finished
 tblock_done_tgroup_id_i  in  TgroupIdBits  group of finished block
 tgroup_done_o  out  1  one-cycle pulse, group fully complete
 tgroup_done_id_o  out  TgroupIdBits  completed group ID
 idle_o  out  1  queue empty and no group in flight
 error_o  out  1  sticky: completion for group not in flight

Function
REQ-008 SHALL keep next_id counter; IDs are assigned in increasing order, wrapping from 2**TgroupIdBits-1 to 0.
REQ-009 SHALL keep, per ID, an in-flight bit and an outstanding-block counter of TblockIdxBits bits.
REQ-010 SHALL assert req_ready_o iff the FIFO is not full and in-flight[next_id] is 0; req_ready_o SHALL not depend on req_valid_i.
REQ-011 SHALL, on req_valid_i and req_ready_o with req_num_tblocks_i != 0, enqueue {pc, dp_addr, num_tblocks, next_id}, set in-flight[next_id], load its counter with req_num_tblocks_i, and increment next_id.
REQ-012 SHALL accept and discard requests with req_num_tblocks_i == 0: no enqueue, no ID consumed, no done pulse.
REQ-013 SHALL drive req_tgroup_id_o = next_id at all times.
REQ-014 SHALL assert disp_start_o iff the FIFO is non-empty, with disp_* showing the head entry; the head is popped when disp_start_o and disp_ready_i are both high.
REQ-015 SHALL use a FIFO without fall-through: an entry accepted in cycle N is visible on disp_* no earlier than cycle N+1.
REQ-016 SHALL hold disp_* stable while disp_start_o is high and disp_ready_i is low.
REQ-017 SHALL, on tblock_done_i for an in-flight ID, decrement that counter; when it decrements from 1, clear in-flight and pulse tgroup_done_o with tgroup_done_id_o in the next cycle.
REQ-018 SHALL ignore tblock_done_i for a not-in-flight ID and set error_o until reset.
REQ-019 SHALL handle acceptance and completion in the same cycle independently; REQ-010 excludes acceptance and completion on the same ID.
REQ-020 SHALL allow simultaneous push and pop when full; the pop does not raise req_ready_o in that cycle.
REQ-021 SHALL assert idle_o iff the FIFO is empty and no in-flight bit is set.
REQ-022 SHALL drive tgroup_done_id_o = 0 when tgroup_done_o is low.

Reset
REQ-023 SHALL, on rst_ni low at a clk_i edge, clear the FIFO, next_id, in-flight bits, counters, error_o and tgroup_done_o, including mid-operation; a pending done pulse is lost.
REQ-024 SHALL show after reset: req_ready_o=1, req_tgroup_id_o=0, disp_start_o=0, disp_*=0, tgroup_done_o=0, tgroup_done_id_o=0, idle_o=1, error_o=0.

Structure
REQ-025 SHALL take the launch-entry struct {pc, dp_addr, num_tblocks, tgroup_id} from the shared bgpu package, parameterised by the widths above.
REQ-026 SHALL use one sub-module, tgroup_launch_fifo: a synchronous-reset FIFO of depth QueueDepth with full/empty outputs; the ID table is local logic.

Verification
REQ-027 Accept pc=0x40, num=3 with disp_ready_i=1 -> disp_start_o high next cycle with id 0, popped; three tblock_done_i on id 0 -> tgroup_done_o pulse with id 0 one cycle after the third; idle_o=1.
REQ-028 With disp_ready_i=0, push 4 requests -> req_ready_o=0 after the fourth; raise disp_ready_i -> entries leave in order with ids 0,1,2,3.
REQ-029 Launch 8 groups, num=1 each, without completions -> req_ready_o=0 with next_id=0; complete id 0 -> req_ready_o=1; next request gets id 0.
REQ-030 Request with num=0 -> accepted, req_tgroup_id_o unchanged, disp_start_o stays 0, no done pulse.
REQ-031 tblock_done_i on id 5 with nothing in flight -> error_o=1 until reset; no done pulse.
REQ-032 Reset with 2 queued and 1 in-flight group -> next cycle all outputs match REQ-024.
